wb_tag_pipe: RTL

Destination-tag and result pipeline for the 5-stage CPU. It carries each issued instruction's write-back tag (valid, rd, load/store flags) and its result data through the ID/EXE, EXE/MEM, MEM/WB and WB registers. It is the producer side of the forwarding/hazard path: it drives the tag, data and load/store flags the forwarding unit compares against, and it turns that unit's load-use suspend request into stall, bubble and flush controls for the front end. It also drives the register-file write port and stall/flush/retire performance counters.

---
 rtl/wb_tag_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wb_tag_pipe.sv
// -----------------------------------------------------------------------------
// wb_tag_pipe
//
// Write-back tag and result pipeline for the 5-stage CPU. Each issued
// instruction carries a tag {v, we, rd, ld, st} through the ID/EXE, EXE/MEM,
// MEM/WB and WB registers. Its result data comes from the ALU at EXE/MEM and
// from memory at MEM/WB.
//
// The block is the producer side of the forwarding path. It publishes the
// effective rd, the data and the load/store flags of each stage. It also turns
// the forwarding unit's load-use suspend request and the branch redirect into
// stall, bubble and flush controls for the front end. WB drives the
// register-file write port.
//
// Ports
//   clk_i, rst_n_i             clock (rising edge), async active-low reset
//   dec_valid_i .. dec_is_store_i
//                              tag of the instruction issuing from ID
//   alu_result_i               EXE result of the instruction in ID/EXE
//   mem_rdata_i                load data of the instruction in EXE/MEM
//   suspend_i                  load-use stall request
//   redirect_i                 taken branch/jump in ID/EXE
//   wr_exe_mem_o/_mem_wb_o/_wb_o
//                              effective rd per stage (0 = no write)
//   data_exe_o/_mem_o/_wb_o    result data per stage
//   is_load_o                  EXE/MEM holds a valid load
//   is_sb_exe_o, is_sb_mem_o   EXE/MEM, MEM/WB hold a valid store
//   pc_stall_o, ifid_stall_o   hold PC and IF/ID
//   ifid_flush_o               clear IF/ID
//   rf_we_o, rf_waddr_o, rf_wdata_o
//                              register-file write port
//   stall_cnt_o, flush_cnt_o, retire_cnt_o
//                              saturating performance counters
// -----------------------------------------------------------------------------
module wb_tag_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             dec_valid_i,
  input  logic             dec_we_i,
  input  logic [4:0]       dec_wr_i,
  input  logic             dec_is_load_i,
  input  logic             dec_is_store_i,
  input  logic [31:0]      alu_result_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic             suspend_i,
  input  logic             redirect_i,
  output logic [4:0]       wr_exe_mem_o,
  output logic [4:0]       wr_mem_wb_o,
  output logic [4:0]       wr_wb_o,
  output logic [31:0]      data_exe_o,
  output logic [31:0]      data_mem_o,
  output logic [31:0]      data_wb_o,
  output logic             is_load_o,
  output logic             is_sb_exe_o,
  output logic             is_sb_mem_o,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic       ld;
    logic       st;
  } tag_t;

  // The load flag is consumed when the MEM/WB data is selected. Later stages
  // therefore carry only the fields they still need.
  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic       st;
  } mw_tag_t;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [4:0] rd;
  } wb_tag_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [4:0] eff_rd(input logic v, input logic we,
                                        input logic [4:0] rd);
    return (v && we && (rd != 5'd0)) ? rd : 5'd0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  tag_t        id_ex, id_ex_nxt;
  tag_t        ex_mem, ex_mem_nxt;
  mw_tag_t     mem_wb, mem_wb_nxt;
  wb_tag_t     wb, wb_nxt;
  logic [31:0] ex_mem_data, ex_mem_data_nxt;
  logic [31:0] mem_wb_data, mem_wb_data_nxt;
  logic [31:0] wb_data;
  logic        take_redirect;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;

  // Suspend takes priority over redirect. The branch in ID/EXE stays held and
  // is redirected again once the stall lifts.
  assign take_redirect = redirect_i & ~suspend_i;

  always_comb begin
    id_ex_nxt       = '{v: dec_valid_i, we: dec_we_i, rd: dec_wr_i,
                        ld: dec_is_load_i, st: dec_is_store_i};
    ex_mem_nxt      = id_ex;
    ex_mem_data_nxt = alu_result_i;

    if (suspend_i) begin
      id_ex_nxt       = id_ex;
      ex_mem_nxt      = '0;
      ex_mem_data_nxt = '0;
    end else if (redirect_i) begin
      id_ex_nxt = '0;
    end

    mem_wb_nxt      = '{v: ex_mem.v, we: ex_mem.we, rd: ex_mem.rd, st: ex_mem.st};
    mem_wb_data_nxt = ex_mem.ld ? mem_rdata_i : ex_mem_data;
    wb_nxt          = '{v: mem_wb.v, we: mem_wb.we, rd: mem_wb.rd};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      id_ex       <= '0;
      ex_mem      <= '0;
      mem_wb      <= '0;
      wb          <= '0;
      ex_mem_data <= '0;
      mem_wb_data <= '0;
      wb_data     <= '0;
    end else begin
      id_ex       <= id_ex_nxt;
      ex_mem      <= ex_mem_nxt;
      mem_wb      <= mem_wb_nxt;
      wb          <= wb_nxt;
      ex_mem_data <= ex_mem_data_nxt;
      mem_wb_data <= mem_wb_data_nxt;
      wb_data     <= mem_wb_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (suspend_i)     stall_cnt  <= sat_inc(stall_cnt);
      if (take_redirect) flush_cnt  <= sat_inc(flush_cnt);
      // WB advances every edge, so a valid MEM/WB tag retires on this edge.
      if (mem_wb.v)      retire_cnt <= sat_inc(retire_cnt);
    end
  end

  assign wr_exe_mem_o = eff_rd(ex_mem.v, ex_mem.we, ex_mem.rd);
  assign wr_mem_wb_o  = eff_rd(mem_wb.v, mem_wb.we, mem_wb.rd);
  assign wr_wb_o      = eff_rd(wb.v, wb.we, wb.rd);

  assign data_exe_o   = ex_mem_data;
  assign data_mem_o   = mem_wb_data;
  assign data_wb_o    = wb_data;

  assign is_load_o    = ex_mem.v & ex_mem.ld;
  assign is_sb_exe_o  = ex_mem.v & ex_mem.st;
  assign is_sb_mem_o  = mem_wb.v & mem_wb.st;

  assign pc_stall_o   = suspend_i;
  assign ifid_stall_o = suspend_i;
  assign ifid_flush_o = take_redirect;

  assign rf_we_o      = wb.v & wb.we & (wb.rd != 5'd0);
  assign rf_waddr_o   = wb.rd;
  assign rf_wdata_o   = wb_data;

  assign stall_cnt_o  = stall_cnt;
  assign flush_cnt_o  = flush_cnt;
  assign retire_cnt_o = retire_cnt;

endmodule
